// File: rtl/cla_seq_adder_ctrl.sv
// cla_seq_adder_ctrl: sequences a WIDTH-bit add through an external 4-bit cla, one nibble per clock,
// with valid/ready handshakes on the operand and result sides.
module cla_seq_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic [3:0]       cla_a,
   output logic [3:0]       cla_b,
   output logic             cla_cin,
   input  logic [3:0]       cla_s,
   input  logic             cla_cout
);
   localparam int NIBBLES = WIDTH / 4;
   localparam int IDXW = $clog2(NIBBLES);
   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
   state_t state_q, state_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic carry_q, carry_d, cin_q, cin_d, cout_q, cout_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cin_q   <= 1'b0;
         cout_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cin_q   <= cin_d;
         cout_q  <= cout_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
      end
   end
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cin_d   = cin_q;
      cout_d  = cout_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      case (state_q)
         IDLE: if (in_valid) begin
            a_d     = op_a;
            b_d     = op_b;
            cin_d   = op_cin;
            idx_d   = '0;
            state_d = ADD;
         end
         ADD: begin
            sum_d[4*idx_q +: 4] = cla_s;
            carry_d = cla_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IDXW'(NIBBLES - 1)) begin
               cout_d  = cla_cout;
               state_d = DONE;
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // cla inputs are forced to zero outside ADD so the external adder sees a quiet bus
   assign cla_a     = (state_q == ADD) ? a_q[4*idx_q +: 4] : 4'h0;
   assign cla_b     = (state_q == ADD) ? b_q[4*idx_q +: 4] : 4'h0;
   assign cla_cin   = (state_q == ADD) ? ((idx_q == '0) ? cin_q : carry_q) : 1'b0;
   assign in_ready  = (state_q == IDLE);
   assign busy      = ~in_ready;
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// tb_cla_seq_adder_ctrl: directed checks of the 16-bit sequencer plus an 8-bit operand sweep,
// each DUT driving a behavioural 4-bit cla.
module tb_cla_seq_adder_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   int n_chk = 0;
   int n_fail = 0;
   logic        iv16 = 0, ir16, ci16 = 0, ov16, or16 = 0, co16, busy16, ccin16, ccout16;
   logic [15:0] a16 = 0, b16 = 0, s16;
   logic [3:0]  ca16, cb16, cs16;
   logic        iv8 = 0, ir8, ci8 = 0, ov8, or8 = 0, co8, busy8, ccin8, ccout8;
   logic [7:0]  a8 = 0, b8 = 0, s8;
   logic [3:0]  ca8, cb8, cs8;
   assign {ccout16, cs16} = {1'b0, ca16} + {1'b0, cb16} + {4'h0, ccin16};
   assign {ccout8, cs8}   = {1'b0, ca8} + {1'b0, cb8} + {4'h0, ccin8};
   cla_seq_adder_ctrl #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .op_a(a16), .op_b(b16),
      .op_cin(ci16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .busy(busy16),
      .cla_a(ca16), .cla_b(cb16), .cla_cin(ccin16), .cla_s(cs16), .cla_cout(ccout16));
   cla_seq_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op_a(a8), .op_b(b8),
      .op_cin(ci8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .busy(busy8),
      .cla_a(ca8), .cla_b(cb8), .cla_cin(ccin8), .cla_s(cs8), .cla_cout(ccout8));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        output int lat, output logic [3:0] cins);
      iv16 = 1; a16 = a; b16 = b; ci16 = ci;
      step();
      iv16 = 0;
      lat = 0;
      cins = '0;
      while (!ov16 && lat < 20) begin
         if (lat < 4) cins[lat] = ccin16;
         step();
         lat++;
      end
   endtask
   task automatic ack16();
      or16 = 1;
      step();
      or16 = 0;
   endtask
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci);
      int k = 0;
      iv8 = 1; a8 = a; b8 = b; ci8 = ci;
      step();
      iv8 = 0;
      while (!ov8 && k < 10) begin
         step();
         k++;
      end
      check("w8_sum", {23'h0, co8, s8}, {23'h0, {1'b0, a} + {1'b0, b} + {8'h0, ci}});
      or8 = 1;
      step();
      or8 = 0;
   endtask
   initial begin
      int lat;
      logic [3:0] cins;
      logic [7:0] bv [6];
      #2;
      check("rst_in_ready", ir16, 1);
      check("rst_out_valid", ov16, 0);
      check("rst_busy", busy16, 0);
      check("rst_sum", {co16, s16}, 0);
      check("rst_cla", {ca16, cb16, ccin16}, 0);
      step();
      rst = 0;
      step();
      run16(16'hFFFF, 16'h0001, 0, lat, cins);
      check("t1_latency", lat, 4);
      check("t1_sum", s16, 16'h0000);
      check("t1_cout", co16, 1);
      check("t1_cla_cin", cins, 4'b1110);
      ack16();
      check("t1_idle", ir16, 1);
      run16(16'h1234, 16'h4321, 1, lat, cins);
      check("t2_sum", s16, 16'h5556);
      check("t2_cout", co16, 0);
      check("t2_cla_cin", cins, 4'b0001);
      ack16();
      check("t2_hold_sum", s16, 16'h5556);
      run16(16'h8000, 16'h8000, 1, lat, cins);
      check("t3_sum", s16, 16'h0001);
      check("t3_cout", co16, 1);
      check("t3_cla_done", {ca16, cb16, ccin16}, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("t3_hold_sum", s16, 16'h0001);
         check("t3_hold_cout", co16, 1);
         check("t3_hold_ov", ov16, 1);
         check("t3_hold_ir", ir16, 0);
      end
      ack16();
      check("t3_release", ov16, 0);
      iv16 = 1; a16 = 16'h0102; b16 = 16'h0203; ci16 = 0;
      step();
      a16 = 16'h1000; b16 = 16'h2000;
      for (int i = 0; i < 4; i++) step();
      check("t4_first_ov", ov16, 1);
      check("t4_first_sum", s16, 16'h0305);
      or16 = 1;
      step();
      or16 = 0;
      check("t4_idle_gap", ir16, 1);
      step();
      iv16 = 0;
      check("t4_second_busy", busy16, 1);
      for (int i = 0; i < 4; i++) step();
      check("t4_second_ov", ov16, 1);
      check("t4_second_sum", s16, 16'h3000);
      ack16();
      iv16 = 1; a16 = 16'h1111; b16 = 16'h1111; ci16 = 0;
      step();
      iv16 = 0;
      step();
      rst = 1;
      #1;
      check("t5_ov", ov16, 0);
      check("t5_ir", ir16, 1);
      check("t5_sum", s16, 0);
      step();
      rst = 0;
      for (int i = 0; i < 6; i++) step();
      check("t5_no_ov", ov16, 0);
      run16(16'h00FF, 16'h0001, 0, lat, cins);
      check("t5_sum2", s16, 16'h0100);
      check("t5_cout2", co16, 0);
      ack16();
      bv[0] = 8'h00; bv[1] = 8'h01; bv[2] = 8'h7F; bv[3] = 8'h80; bv[4] = 8'hFF; bv[5] = 8'h5A;
      for (int a = 0; a < 256; a++)
         for (int j = 0; j < 6; j++)
            for (int c = 0; c < 2; c++)
               run8(8'(a), (j == 5) ? 8'(a) ^ bv[j] : bv[j], c[0]);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
